sd_sector_arbiter: RTL and testbench

- Core-side controller between up to two disk-emulation requesters and the user_io SD-card emulation port (sd_lba/sd_rd/sd_wr/sd_ack/sd_dout*/sd_din*).
- Arbitrates sector requests round-robin and drives the sector request to user_io.
- Crosses the SPI-clocked strobes and ack into the core clock domain.
- Streams 512 data bytes between the IO controller and the granted requester's sector buffer port.

---
 rtl/sd_arb_pkg.sv | 9 +
 rtl/sd_arb_sync_edge.sv | 30 +++
 rtl/sd_sector_arbiter.sv | 128 ++++++++++++
 tb/tb_sd_sector_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector arbiter.
package sd_arb_pkg;
  localparam int SECTOR_BYTES_DEF = 512;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;
endpackage

// File: rtl/sd_arb_sync_edge.sv
// N-flop synchroniser; EDGE selects a rising-edge pulse or the synchronised level.
module sync_edge #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[STAGES-2:0], din};
  end

  generate
    if (EDGE) begin : g_edge
      logic hist;
      always_ff @(posedge clk) begin
        if (!reset_n) hist <= 1'b0;
        else          hist <= sync[STAGES-1];
      end
      assign dout = sync[STAGES-1] & ~hist;
    end else begin : g_level
      assign dout = sync[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter of two sector requesters onto the user_io SD emulation port,
// streaming one sector between the SPI-side strobes and the grantee's buffer.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int SECTOR_BYTES = SECTOR_BYTES_DEF,
  parameter int ADDR_W       = $clog2(SECTOR_BYTES),
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_rd,
  input  logic [1:0]        req_wr,
  input  logic [63:0]       req_lba,
  output logic [1:0]        done,
  output logic              busy,
  output logic              grant_id,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              buf_we,
  input  logic [7:0]        buf_rdata,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [7:0]        sd_dout,
  input  logic              sd_dout_strobe,
  output logic [7:0]        sd_din,
  input  logic              sd_din_strobe
);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(SECTOR_BYTES);

  state_t          state, state_nxt;
  logic            ack_s, dstb_e, istb_e;
  logic            last_grant, dir, rd_pend;
  logic [ADDR_W:0] cnt;
  logic [1:0]      pend;
  logic            grant_vld, grant_nxt, cnt_full;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_ack  (.clk, .reset_n, .din(sd_ack),         .dout(ack_s));
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_dstb (.clk, .reset_n, .din(sd_dout_strobe), .dout(dstb_e));
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_istb (.clk, .reset_n, .din(sd_din_strobe),  .dout(istb_e));

  // On a tie the requester that did not go last wins.
  assign pend      = req_rd | req_wr;
  assign grant_vld = |pend;
  assign grant_nxt = (&pend) ? ~last_grant : pend[1];
  assign cnt_full  = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sd_rd     = 1'b0;
    sd_wr     = 1'b0;
    done      = '0;
    case (state)
      IDLE: if (grant_vld) state_nxt = REQ;
      REQ: begin
        sd_rd = (dir == DIR_RD);
        sd_wr = (dir == DIR_WR);
        if (ack_s) state_nxt = XFER;
      end
      XFER: if (!ack_s) state_nxt = FIN;
      FIN: begin
        done[grant_id] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      dir        <= DIR_RD;
      sd_lba     <= '0;
      cnt        <= '0;
      rd_pend    <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      buf_we     <= 1'b0;
      sd_din     <= '0;
    end else begin
      buf_we  <= 1'b0;
      rd_pend <= 1'b0;
      case (state)
        IDLE: if (grant_vld) begin
          grant_id <= grant_nxt;
          busy     <= 1'b1;
          dir      <= req_rd[grant_nxt] ? DIR_RD : DIR_WR;
          sd_lba   <= grant_nxt ? req_lba[63:32] : req_lba[31:0];
          cnt      <= '0;
        end
        XFER: begin
          if (dir == DIR_RD) begin
            if (dstb_e && !cnt_full) begin
              buf_addr  <= cnt[ADDR_W-1:0];
              buf_wdata <= sd_dout;
              buf_we    <= 1'b1;
              cnt       <= cnt + 1'b1;
            end
          end else begin
            // Address goes out on the strobe; buffer data is valid one cycle later.
            if (istb_e && !cnt_full) begin
              buf_addr <= cnt[ADDR_W-1:0];
              rd_pend  <= 1'b1;
            end
            if (rd_pend) begin
              sd_din <= buf_rdata;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        FIN: begin
          busy       <= 1'b0;
          last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Randomized self-checking bench for sd_sector_arbiter against a transaction-level model.
module tb_sd_sector_arbiter;
  localparam int SB = 512;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  req_rd = '0, req_wr = '0;
  logic [63:0] req_lba = '0;
  logic [1:0]  done;
  logic        busy, grant_id, buf_we, sd_rd, sd_wr;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata, buf_rdata, sd_din;
  logic [7:0]  sd_dout = '0;
  logic [31:0] sd_lba;
  logic        sd_ack = 1'b0, sd_dout_strobe = 1'b0, sd_din_strobe = 1'b0;

  int          nvec = 0, nerr = 0;
  int          ndone[2] = '{0, 0};
  bit          last_g = 1'b1;
  logic [16:0] wq[$];

  always #5 clk = ~clk;

  // Buffer model: byte at address a reads back as ~a.
  assign buf_rdata = ~buf_addr[7:0];

  sd_sector_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .done(done), .busy(busy), .grant_id(grant_id), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_dout(sd_dout),
    .sd_dout_strobe(sd_dout_strobe), .sd_din(sd_din), .sd_din_strobe(sd_din_strobe)
  );

  always @(negedge clk) begin
    if (buf_we) wq.push_back({buf_addr, buf_wdata});
    if (done[0]) ndone[0]++;
    if (done[1]) ndone[1]++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {done, busy, grant_id, buf_addr, buf_wdata, buf_we, sd_lba, sd_rd, sd_wr, sd_din};
  endfunction

  function automatic bit pick(input logic [1:0] p);
    return (&p) ? !last_g : p[1];
  endfunction

  // One SPI-side byte strobe, slow relative to clk.
  task automatic strobe(input bit din_side, input logic [7:0] b);
    @(negedge clk);
    sd_dout = b;
    if (din_side) sd_din_strobe = 1'b1;
    else          sd_dout_strobe = 1'b1;
    repeat (3) @(negedge clk);
    sd_din_strobe  = 1'b0;
    sd_dout_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_xfer(input int n, input bit do_rst);
    bit          id, wr;
    logic [31:0] lba;
    logic [7:0]  e;
    logic [7:0]  exp_d[$];
    int          t, nw, d0;
    id  = pick(req_rd | req_wr);
    wr  = !req_rd[id];
    lba = id ? req_lba[63:32] : req_lba[31:0];
    t = 0;
    while (!(sd_rd | sd_wr) && t < 20) begin @(negedge clk); t++; end
    chk("cmd_timeout", 64'(t < 20), 64'd1);
    if (t >= 20) return;
    chk("grant_id", grant_id, id);
    chk("sd_lba", sd_lba, lba);
    chk("sd_rd", sd_rd, !wr);
    chk("sd_wr", sd_wr, wr);
    chk("busy", busy, 1);
    sd_ack = 1'b1;
    t = 0;
    while ((sd_rd | sd_wr) && t < 20) begin @(negedge clk); t++; end
    chk("ack_timeout", 64'(t < 20), 64'd1);
    wq.delete();
    for (int k = 0; k < n; k++) begin
      if (!wr) begin
        e = 8'($urandom);
        exp_d.push_back(e);
        strobe(1'b0, e);
      end else begin
        strobe(1'b1, 8'h00);
        e = ~8'(k < SB ? k : SB - 1);
        chk("sd_din", sd_din, e);
      end
    end
    if (!wr) begin
      nw = (n < SB) ? n : SB;
      chk("we_count", wq.size(), nw);
      for (int k = 0; k < wq.size() && k < nw; k++)
        chk("buf_write", wq[k], {9'(k), exp_d[k]});
    end
    if (do_rst) begin
      d0 = ndone[0] + ndone[1];
      reset_n = 1'b0;
      sd_ack  = 1'b0;
      @(negedge clk);
      chk("midrst_outs", all_outs(), 64'd0);
      req_rd = '0;
      req_wr = '0;
      repeat (4) @(negedge clk);
      chk("midrst_nodone", ndone[0] + ndone[1], d0);
      reset_n = 1'b1;
      last_g  = 1'b1;
      return;
    end
    d0 = ndone[id];
    sd_ack = 1'b0;
    t = 0;
    while (!done[id] && t < 20) begin @(negedge clk); t++; end
    chk("done_timeout", 64'(t < 20), 64'd1);
    chk("done_other", done[!id], 0);
    req_rd[id] = 1'b0;
    req_wr[id] = 1'b0;
    last_g = id;
    @(negedge clk);
    chk("busy_clear", busy, 0);
    chk("done_once", ndone[id], d0 + 1);
  endtask

  initial begin
    logic [1:0] p, r;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    req_lba[31:0] = 32'h0000_1234;
    req_rd[0] = 1'b1;
    run_xfer(SB, 1'b0);

    req_lba[63:32] = 32'hDEAD_BEEF;
    req_wr[1] = 1'b1;
    run_xfer(SB + 1, 1'b0);

    for (int rep = 0; rep < 2; rep++) begin
      req_lba = {$urandom, $urandom};
      req_rd  = 2'b11;
      run_xfer(8, 1'b0);
      run_xfer(8, 1'b0);
    end

    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    run_xfer(5, 1'b0);

    req_rd[1] = 1'b1;
    run_xfer(100, 1'b0);

    req_rd[0] = 1'b1;
    run_xfer(37, 1'b1);
    req_lba = {$urandom, $urandom};
    req_rd[1] = 1'b1;
    run_xfer(10, 1'b0);

    for (int it = 0; it < 6; it++) begin
      p = 2'($urandom_range(1, 3));
      r = 2'($urandom);
      req_lba = {$urandom, $urandom};
      req_rd  = p & r;
      req_wr  = p & ~r;
      for (int g = 0; g < 2 && (req_rd | req_wr) != 0; g++)
        run_xfer($urandom_range(1, 20), 1'b0);
      req_rd = '0;
      req_wr = '0;
      repeat (2) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
